// File: rtl/autocorr_sequencer.sv
// Frame autocorrelation sequencer: capture FRAME_LEN serial bits, then compute and present
// the +/-1 autocorrelation for lags 0..MAX_LAG. Optional macro AUTOCORR_ABORT_EN adds abort_i.
module autocorr_sequencer #(
    parameter int FRAME_LEN = 8,
    parameter int MAX_LAG   = 3,
    localparam int CW = $clog2(FRAME_LEN + 1) + 1,
    localparam int LW = (MAX_LAG > 0) ? $clog2(MAX_LAG + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 in_i,
    input  logic                 in_valid_i,
    output logic                 busy_o,
    output logic [LW-1:0]        lag_o,
    output logic signed [CW-1:0] corr_o,
    output logic                 corr_valid_o,
    input  logic                 corr_ready_i,
`ifdef AUTOCORR_ABORT_EN
    input  logic                 abort_i,
`endif
    output logic                 done_o
);

    localparam int IW = $clog2(FRAME_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_COMPUTE,
        S_PRESENT,
        S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic signed [CW-1:0]  acc_q, acc_d;
    logic [LW-1:0]         lag_q, lag_d;
    logic [FRAME_LEN-1:0]  s_q, s_d;
    logic [FRAME_LEN-1:0]  s_shift;
    logic                  last_term;
    logic                  abort_w;

`ifdef AUTOCORR_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // s_shift[i] is s[i+lag]; the same counter walks the capture slot and the term index
    assign s_shift   = s_q >> lag_q;
    assign last_term = (cnt_q == (IW'(FRAME_LEN - 1) - IW'(lag_q)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lag_q   <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lag_q   <= lag_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lag_d   = lag_q;
        s_d     = s_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    lag_d   = '0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (in_valid_i) begin
                    s_d[cnt_q] = in_i;
                    if (cnt_q == IW'(FRAME_LEN - 1)) begin
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                acc_d = acc_q + ((s_q[cnt_q] == s_shift[cnt_q]) ? CW'(1) : {CW{1'b1}});
                if (last_term) begin
                    cnt_d   = '0;
                    state_d = S_PRESENT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRESENT: begin
                if (corr_ready_i) begin
                    if (lag_q == LW'(MAX_LAG)) begin
                        state_d = S_FINISH;
                    end else begin
                        lag_d   = lag_q + 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // abort wins over any handshake in the same cycle
        if (abort_w && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign corr_valid_o = (state_q == S_PRESENT);
    assign done_o       = (state_q == S_FINISH);
    assign lag_o        = lag_q;
    assign corr_o       = (state_q == S_PRESENT) ? acc_q : '0;

endmodule
